// File: rtl/hazard_forward_ctrl.sv
// ---------------------------------------------------------------------------
// hazard_forward_ctrl
//
// EX-stage operand forwarding across NUM_FWD write-back sources, with the
// youngest (lowest index) source winning. Also detects load-use hazards and
// sequences a LOAD_LAT-cycle stall. Sits between the ID/EX pipeline register
// and the ALU/store-data muxes.
//
// Optional feature macro: HAZARD_STATS_EN
//   When defined, the block adds saturating Stall_Count / Fwd_Count outputs.
//   When undefined, those ports and their counters are absent.
//
// Ports
//   Clk, Rst_n           clock (rising edge), synchronous active-low reset
//   Flush                branch/jump flush, aborts any stall sequence
//   IF_ID_rs/rt          decode-stage source registers
//   IF_ID_UsesRs/UsesRt  decode instruction actually reads that operand
//   ID_EX_rs/rt/rd       EX-stage sources and destination
//   ID_EX_RegWrite/MemRead  EX-stage control bits
//   Fwd_RegWrite         per-source write enable (0=EX_MEM,1=MEM_WB,2=WB_LATE)
//   Fwd_rd               per-source destination, source k at [k*REG_AW +: REG_AW]
//   ALU_input_rs/rt      operand selects: 0 = ID_EX value, k+1 = source k
//   WriteMEMData_Signal  store-data select, mirrors ALU_input_rt
//   Stall                load-use stall active
//   PC_Write, IF_ID_Write  ~Stall
//   ID_EX_Bubble         Stall
//   Stall_Count, Fwd_Count (HAZARD_STATS_EN only) saturating cycle counters
//
// Stall FSM
//   state | meaning
//   IDLE  | no sequence in progress; stalls combinationally on a fresh hazard
//   HOLD  | extra stall cycles of a multi-cycle load-use; cnt_q counts down
// ---------------------------------------------------------------------------
module hazard_forward_ctrl #(
  parameter  int REG_AW   = 5,
  parameter  int NUM_FWD  = 2,
  parameter  int LOAD_LAT = 1,
  localparam int FSEL_W   = $clog2(NUM_FWD + 1)
) (
  input  logic                      Clk,
  input  logic                      Rst_n,
  input  logic                      Flush,
  input  logic [REG_AW-1:0]         IF_ID_rs,
  input  logic [REG_AW-1:0]         IF_ID_rt,
  input  logic                      IF_ID_UsesRs,
  input  logic                      IF_ID_UsesRt,
  input  logic [REG_AW-1:0]         ID_EX_rs,
  input  logic [REG_AW-1:0]         ID_EX_rt,
  input  logic [REG_AW-1:0]         ID_EX_rd,
  input  logic                      ID_EX_RegWrite,
  input  logic                      ID_EX_MemRead,
  input  logic [NUM_FWD-1:0]        Fwd_RegWrite,
  input  logic [NUM_FWD*REG_AW-1:0] Fwd_rd,
  output logic [FSEL_W-1:0]         ALU_input_rs,
  output logic [FSEL_W-1:0]         ALU_input_rt,
  output logic [FSEL_W-1:0]         WriteMEMData_Signal,
  output logic                      Stall,
  output logic                      PC_Write,
  output logic                      IF_ID_Write,
  output logic                      ID_EX_Bubble
`ifdef HAZARD_STATS_EN
  ,
  output logic [15:0]               Stall_Count,
  output logic [15:0]               Fwd_Count
`endif
);

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } state_t;

  state_t      state_q, state_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [FSEL_W-1:0] sel_rs, sel_rt;
  logic        haz;
  logic        stall_raw;

  // Forwarding: scan from the oldest source down so the youngest match is
  // the last assignment and therefore wins.
  always_comb begin
    sel_rs = '0;
    sel_rt = '0;
    for (int k = NUM_FWD - 1; k >= 0; k--) begin
      if (Fwd_RegWrite[k] && (Fwd_rd[k*REG_AW +: REG_AW] == ID_EX_rs) &&
          (ID_EX_rs != '0)) begin
        sel_rs = FSEL_W'(k + 1);
      end
      if (Fwd_RegWrite[k] && (Fwd_rd[k*REG_AW +: REG_AW] == ID_EX_rt) &&
          (ID_EX_rt != '0)) begin
        sel_rt = FSEL_W'(k + 1);
      end
    end
  end

  always_comb begin
    haz = ID_EX_MemRead && ID_EX_RegWrite && (ID_EX_rd != '0) &&
          ((IF_ID_UsesRs && (IF_ID_rs == ID_EX_rd)) ||
           (IF_ID_UsesRt && (IF_ID_rt == ID_EX_rd)));
  end

  // Next-state / stall. The IDLE stall cycle is the first of LOAD_LAT, so
  // HOLD only has to cover LOAD_LAT-1 further cycles (cnt from LOAD_LAT-2
  // down to 0). A hazard seen while HOLD exits is ignored: the bubble has
  // already displaced the load from ID/EX.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    stall_raw = 1'b0;
    if (Flush) begin
      state_d = IDLE;
      cnt_d   = 3'd0;
    end else begin
      unique case (state_q)
        IDLE: begin
          stall_raw = haz;
          if (haz && (LOAD_LAT > 1)) begin
            state_d = HOLD;
            cnt_d   = 3'(LOAD_LAT - 2);
          end
        end
        HOLD: begin
          stall_raw = 1'b1;
          if (cnt_q != 3'd0) begin
            cnt_d = cnt_q - 3'd1;
          end else begin
            state_d = IDLE;
          end
        end
        default: begin
          state_d = IDLE;
          cnt_d   = 3'd0;
        end
      endcase
    end
  end

  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      state_q <= IDLE;
      cnt_q   <= 3'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Outputs are held at their safe values for as long as reset is low.
  always_comb begin
    ALU_input_rs        = Rst_n ? sel_rs : '0;
    ALU_input_rt        = Rst_n ? sel_rt : '0;
    WriteMEMData_Signal = ALU_input_rt;
    Stall               = Rst_n & stall_raw;
    PC_Write            = ~Stall;
    IF_ID_Write         = ~Stall;
    ID_EX_Bubble        = Stall;
  end

`ifdef HAZARD_STATS_EN
  logic [15:0] stall_cnt_q, stall_cnt_d;
  logic [15:0] fwd_cnt_q, fwd_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    fwd_cnt_d   = fwd_cnt_q;
    if (Stall && (stall_cnt_q != 16'hFFFF)) begin
      stall_cnt_d = stall_cnt_q + 16'd1;
    end
    if (((ALU_input_rs != '0) || (ALU_input_rt != '0)) &&
        (fwd_cnt_q != 16'hFFFF)) begin
      fwd_cnt_d = fwd_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      stall_cnt_q <= 16'd0;
      fwd_cnt_q   <= 16'd0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      fwd_cnt_q   <= fwd_cnt_d;
    end
  end

  assign Stall_Count = stall_cnt_q;
  assign Fwd_Count   = fwd_cnt_q;
`endif

endmodule

// File: tb/tb_hazard_forward_ctrl.sv
// ---------------------------------------------------------------------------
// Testbench for hazard_forward_ctrl. Three instances share one stimulus
// stream and differ only in LOAD_LAT (1, 3, 4). The driver pushes the
// hand-computed expectation for every driven cycle into a scoreboard queue;
// a monitor on the falling edge pops and compares. With HAZARD_STATS_EN
// defined, a fourth LOAD_LAT=2 instance exercises the statistics counters.
// ---------------------------------------------------------------------------
module tb_hazard_forward_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       flush;
  logic [4:0] if_rs, if_rt;
  logic       uses_rs, uses_rt;
  logic [4:0] ex_rs, ex_rt, ex_rd;
  logic       ex_rw, ex_mr;
  logic [1:0] fwd_rw;
  logic [4:0] fwd_rd0, fwd_rd1;

  always #5 clk = ~clk;

  logic [1:0] rs1, rt1, wm1, rs3, rt3, wm3, rs4, rt4, wm4;
  logic       st1, pc1, iw1, bb1, st3, pc3, iw3, bb3, st4, pc4, iw4, bb4;

`ifdef HAZARD_STATS_EN
  logic [15:0] sc1, fc1, sc3, fc3, sc4, fc4, sc2, fc2;
  logic [1:0]  rs2, rt2, wm2;
  logic        st2, pc2, iw2, bb2;
`endif

  hazard_forward_ctrl #(.LOAD_LAT(1)) u1 (
    .Clk(clk), .Rst_n(rst_n), .Flush(flush),
    .IF_ID_rs(if_rs), .IF_ID_rt(if_rt),
    .IF_ID_UsesRs(uses_rs), .IF_ID_UsesRt(uses_rt),
    .ID_EX_rs(ex_rs), .ID_EX_rt(ex_rt), .ID_EX_rd(ex_rd),
    .ID_EX_RegWrite(ex_rw), .ID_EX_MemRead(ex_mr),
    .Fwd_RegWrite(fwd_rw), .Fwd_rd({fwd_rd1, fwd_rd0}),
    .ALU_input_rs(rs1), .ALU_input_rt(rt1), .WriteMEMData_Signal(wm1),
    .Stall(st1), .PC_Write(pc1), .IF_ID_Write(iw1), .ID_EX_Bubble(bb1)
`ifdef HAZARD_STATS_EN
    , .Stall_Count(sc1), .Fwd_Count(fc1)
`endif
  );

  hazard_forward_ctrl #(.LOAD_LAT(3)) u3 (
    .Clk(clk), .Rst_n(rst_n), .Flush(flush),
    .IF_ID_rs(if_rs), .IF_ID_rt(if_rt),
    .IF_ID_UsesRs(uses_rs), .IF_ID_UsesRt(uses_rt),
    .ID_EX_rs(ex_rs), .ID_EX_rt(ex_rt), .ID_EX_rd(ex_rd),
    .ID_EX_RegWrite(ex_rw), .ID_EX_MemRead(ex_mr),
    .Fwd_RegWrite(fwd_rw), .Fwd_rd({fwd_rd1, fwd_rd0}),
    .ALU_input_rs(rs3), .ALU_input_rt(rt3), .WriteMEMData_Signal(wm3),
    .Stall(st3), .PC_Write(pc3), .IF_ID_Write(iw3), .ID_EX_Bubble(bb3)
`ifdef HAZARD_STATS_EN
    , .Stall_Count(sc3), .Fwd_Count(fc3)
`endif
  );

  hazard_forward_ctrl #(.LOAD_LAT(4)) u4 (
    .Clk(clk), .Rst_n(rst_n), .Flush(flush),
    .IF_ID_rs(if_rs), .IF_ID_rt(if_rt),
    .IF_ID_UsesRs(uses_rs), .IF_ID_UsesRt(uses_rt),
    .ID_EX_rs(ex_rs), .ID_EX_rt(ex_rt), .ID_EX_rd(ex_rd),
    .ID_EX_RegWrite(ex_rw), .ID_EX_MemRead(ex_mr),
    .Fwd_RegWrite(fwd_rw), .Fwd_rd({fwd_rd1, fwd_rd0}),
    .ALU_input_rs(rs4), .ALU_input_rt(rt4), .WriteMEMData_Signal(wm4),
    .Stall(st4), .PC_Write(pc4), .IF_ID_Write(iw4), .ID_EX_Bubble(bb4)
`ifdef HAZARD_STATS_EN
    , .Stall_Count(sc4), .Fwd_Count(fc4)
`endif
  );

`ifdef HAZARD_STATS_EN
  hazard_forward_ctrl #(.LOAD_LAT(2)) u2 (
    .Clk(clk), .Rst_n(rst_n), .Flush(flush),
    .IF_ID_rs(if_rs), .IF_ID_rt(if_rt),
    .IF_ID_UsesRs(uses_rs), .IF_ID_UsesRt(uses_rt),
    .ID_EX_rs(ex_rs), .ID_EX_rt(ex_rt), .ID_EX_rd(ex_rd),
    .ID_EX_RegWrite(ex_rw), .ID_EX_MemRead(ex_mr),
    .Fwd_RegWrite(fwd_rw), .Fwd_rd({fwd_rd1, fwd_rd0}),
    .ALU_input_rs(rs2), .ALU_input_rt(rt2), .WriteMEMData_Signal(wm2),
    .Stall(st2), .PC_Write(pc2), .IF_ID_Write(iw2), .ID_EX_Bubble(bb2),
    .Stall_Count(sc2), .Fwd_Count(fc2)
  );
`endif

  typedef struct {
    logic [1:0] rs;
    logic [1:0] rt;
    logic       s1;
    logic       s3;
    logic       s4;
    string      nm;
  } exp_t;

  exp_t sb[$];
  exp_t e;
  int   tests = 0;
  int   fails = 0;

  task automatic chk(input string nm, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic chk_dut(input string nm, input logic [1:0] rs, rt, wm,
                         input logic st, pc, iw, bb,
                         input logic [1:0] ers, ert, input logic est);
    chk({nm, ".rs"},    int'(rs), int'(ers));
    chk({nm, ".rt"},    int'(rt), int'(ert));
    chk({nm, ".wmd"},   int'(wm), int'(ert));
    chk({nm, ".stall"}, int'(st), int'(est));
    chk({nm, ".pcw"},   int'(pc), int'(!est));
    chk({nm, ".ifw"},   int'(iw), int'(!est));
    chk({nm, ".bub"},   int'(bb), int'(est));
  endtask

  // Monitor: every driven cycle has one queued expectation.
  always @(negedge clk) begin
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk_dut({e.nm, "/L1"}, rs1, rt1, wm1, st1, pc1, iw1, bb1, e.rs, e.rt, e.s1);
      chk_dut({e.nm, "/L3"}, rs3, rt3, wm3, st3, pc3, iw3, bb3, e.rs, e.rt, e.s3);
      chk_dut({e.nm, "/L4"}, rs4, rt4, wm4, st4, pc4, iw4, bb4, e.rs, e.rt, e.s4);
    end
  end

  task automatic set_in(input logic r, fl, input logic [4:0] irs, irt,
                        input logic ur, ut, input logic [4:0] xrs, xrt, xrd,
                        input logic rw, mr, input logic [1:0] frw,
                        input logic [4:0] fd0, fd1);
    @(posedge clk);
    #1;
    rst_n = r;  flush = fl;
    if_rs = irs; if_rt = irt; uses_rs = ur; uses_rt = ut;
    ex_rs = xrs; ex_rt = xrt; ex_rd = xrd; ex_rw = rw; ex_mr = mr;
    fwd_rw = frw; fwd_rd0 = fd0; fwd_rd1 = fd1;
  endtask

  task automatic drive(input logic r, fl, input logic [4:0] irs, irt,
                       input logic ur, ut, input logic [4:0] xrs, xrt, xrd,
                       input logic rw, mr, input logic [1:0] frw,
                       input logic [4:0] fd0, fd1,
                       input logic [1:0] ers, ert, input logic es1, es3, es4,
                       input string nm);
    exp_t x;
    set_in(r, fl, irs, irt, ur, ut, xrs, xrt, xrd, rw, mr, frw, fd0, fd1);
    x.rs = ers; x.rt = ert; x.s1 = es1; x.s3 = es3; x.s4 = es4; x.nm = nm;
    sb.push_back(x);
  endtask

  // Common vectors: idle, and lw r8 in EX with decode reading r8 as rs.
  task automatic idle(input logic es1, es3, es4, input string nm);
    drive(1,0, 0,0,0,0, 0,0,0,0,0, 2'b00,0,0, 0,0, es1,es3,es4, nm);
  endtask

  task automatic haz_rs(input logic es1, es3, es4, input string nm);
    drive(1,0, 8,0,1,0, 0,0,8,1,1, 2'b00,0,0, 0,0, es1,es3,es4, nm);
  endtask

  initial begin
    rst_n = 0; flush = 0; if_rs = 0; if_rt = 0; uses_rs = 0; uses_rt = 0;
    ex_rs = 0; ex_rt = 0; ex_rd = 0; ex_rw = 0; ex_mr = 0;
    fwd_rw = 0; fwd_rd0 = 0; fwd_rd1 = 0;

    // Reset held low with live forwarding match and hazard: everything safe.
    drive(0,0, 8,0,1,0, 5,5,8,1,1, 2'b11,5,5, 0,0, 0,0,0, "rst_hold");
    // Forwarding patterns.
    drive(1,0, 0,0,0,0, 5,5,0,0,0, 2'b11,5,5,   1,1, 0,0,0, "dual_prio");
    drive(1,0, 0,0,0,0, 0,7,0,0,0, 2'b11,0,7,   0,2, 0,0,0, "r0_indep");
    drive(1,0, 0,0,0,0, 3,4,0,0,0, 2'b10,3,3,   2,0, 0,0,0, "src1_only");
    drive(1,0, 0,0,0,0, 10,11,0,0,0, 2'b11,11,10, 2,1, 0,0,0, "cross");
    drive(1,0, 0,0,0,0, 3,3,0,0,0, 2'b00,3,3,   0,0, 0,0,0, "no_we");

    // Load-use on rs, forwarding on rs stays valid during the stall.
    drive(1,0, 8,0,1,0, 6,0,8,1,1, 2'b01,6,0, 1,0, 1,1,1, "lu_c0");
    idle(0,1,1, "lu_c1");
    idle(0,1,1, "lu_c2");
    idle(0,0,1, "lu_c3");
    idle(0,0,0, "lu_c4");

    // rt match with UsesRt=0: no stall; then with UsesRt=1: stall.
    drive(1,0, 9,8,1,0, 0,0,8,1,1, 2'b00,0,0, 0,0, 0,0,0, "rt_unused");
    drive(1,0, 9,8,1,1, 0,0,8,1,1, 2'b00,0,0, 0,0, 1,1,1, "rt_used_c0");
    idle(0,1,1, "rt_used_c1");
    idle(0,1,1, "rt_used_c2");
    idle(0,0,1, "rt_used_c3");
    idle(0,0,0, "rt_used_c4");

    // Not a load-use: RegWrite low, or destination r0.
    drive(1,0, 8,0,1,0, 0,0,8,0,1, 2'b00,0,0, 0,0, 0,0,0, "no_regwrite");
    drive(1,0, 0,0,1,0, 0,0,0,1,1, 2'b00,0,0, 0,0, 0,0,0, "rd_zero");

    // Hazard present while L3's HOLD exits is ignored there.
    haz_rs(1,1,1, "exit_c0");
    idle  (0,1,1, "exit_c1");
    haz_rs(1,1,1, "exit_c2");
    idle  (0,0,1, "exit_c3");
    idle  (0,0,0, "exit_c4");

    // Flush in the 2nd stall cycle, hazard still asserted.
    haz_rs(1,1,1, "flush_c0");
    drive(1,1, 8,0,1,0, 6,0,8,1,1, 2'b01,6,0, 1,0, 0,0,0, "flush_c1");
    idle  (0,0,0, "flush_c2");
    idle  (0,0,0, "flush_c3");

    // Reset in the 2nd stall cycle with forwarding match present.
    haz_rs(1,1,1, "rstmid_c0");
    drive(0,0, 8,0,1,0, 6,6,8,1,1, 2'b11,6,6, 0,0, 0,0,0, "rstmid_c1");
    idle  (0,0,0, "rstmid_c2");
    idle  (0,0,0, "rstmid_c3");

    @(posedge clk);
    @(negedge clk);
    #1;
    chk("sb_drained", sb.size(), 0);

`ifdef HAZARD_STATS_EN
    set_in(0,0, 0,0,0,0, 0,0,0,0,0, 2'b00,0,0);
    for (int h = 0; h < 3; h++) begin
      set_in(1,0, 8,0,1,0, 0,0,8,1,1, 2'b00,0,0);
      set_in(1,0, 0,0,0,0, 0,0,0,0,0, 2'b00,0,0);
      set_in(1,0, 0,0,0,0, 0,0,0,0,0, 2'b00,0,0);
    end
    @(negedge clk);
    chk("stall_count_3x2", int'(sc2), 6);
    chk("fwd_count_zero", int'(fc2), 0);
    set_in(1,0, 0,0,0,0, 5,0,0,0,0, 2'b01,5,0);
    set_in(1,0, 0,0,0,0, 0,0,0,0,0, 2'b00,0,0);
    @(negedge clk);
    chk("fwd_count_one", int'(fc2), 1);
    set_in(1,0, 8,0,1,0, 0,0,8,1,1, 2'b00,0,0);
    repeat (65540) @(posedge clk);
    @(negedge clk);
    chk("stall_count_sat", int'(sc2), 65535);
    chk("fwd_count_hold", int'(fc2), 1);
    set_in(0,0, 0,0,0,0, 0,0,0,0,0, 2'b00,0,0);
    @(negedge clk);
    @(posedge clk);
    #1;
    chk("stall_count_rst", int'(sc2), 0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/hazard_forward_ctrl.md
# hazard_forward_ctrl

Parametrised successor to the pipeline's two-stage forwarding logic. Resolves operand forwarding for the EX stage across `NUM_FWD` downstream write-back sources, with strict youngest-first priority. Also owns load-use hazard detection with a multi-cycle stall sequencer sized by `LOAD_LAT`. Sits between the ID/EX pipeline register and the ALU/store-data muxes, and drives PC/IF_ID write enables and the ID/EX bubble.

## Interface
- `REG_AW`, 5: register address width.
- `NUM_FWD`, 2: forwarding sources, 1..3. Index 0 = EX_MEM, 1 = MEM_WB, 2 = WB_LATE.
- `LOAD_LAT`, 1: stall cycles per load-use hazard, 1..7.
- `FSEL_W`, `$clog2(NUM_FWD+1)`: select width (localparam).

Ports (name, direction, width, meaning):
- `Clk` in 1: clock, rising edge.
- `Rst_n` in 1: synchronous reset, active-low.
- `Flush` in 1: branch/jump flush; aborts any stall sequence.
- `IF_ID_rs`, `IF_ID_rt` in `REG_AW`: source registers of the decoding instruction.
- `IF_ID_UsesRs`, `IF_ID_UsesRt` in 1: the decoding instruction actually reads that operand.
- `ID_EX_rs`, `ID_EX_rt` in `REG_AW`: source registers of the EX instruction.
- `ID_EX_rd` in `REG_AW`: destination register of the EX instruction.
- `ID_EX_RegWrite`, `ID_EX_MemRead` in 1: control bits of the EX instruction.
- `Fwd_RegWrite` in `NUM_FWD`: per-source write enable.
- `Fwd_rd` in `NUM_FWD*REG_AW`: per-source destination; source k occupies bits `[k*REG_AW +: REG_AW]`.
- `ALU_input_rs`, `ALU_input_rt` out `FSEL_W`: 0 = ID_EX value; k+1 = source k.
- `WriteMEMData_Signal` out `FSEL_W`: store-data select; always equals `ALU_input_rt`.
- `Stall` out 1: load-use stall active.
- `PC_Write`, `IF_ID_Write` out 1: equal to `~Stall`.
- `ID_EX_Bubble` out 1: equal to `Stall`; zeroes ID/EX control.

## Operation
- **Forwarding, per operand independently.**
  - Source k matches when `Fwd_RegWrite[k]` is 1, `Fwd_rd_k == operand`, and `operand != 0`.
  - The lowest matching k wins (youngest data). No match gives select 0.
  - Register 0 never forwards, even when a source writes r0.
- **Hazard detect (combinational).** `haz` is asserted when all of the following hold:
  - `ID_EX_MemRead` is 1, `ID_EX_RegWrite` is 1, and `ID_EX_rd != 0`;
  - either (`IF_ID_UsesRs` and `IF_ID_rs == ID_EX_rd`) or (`IF_ID_UsesRt` and `IF_ID_rt == ID_EX_rd`).
- **Stall FSM (states IDLE, HOLD; 3-bit counter `cnt`).**
  - IDLE, `haz`=1, `LOAD_LAT`=1: remain IDLE. Single stall cycle.
  - IDLE, `haz`=1, `LOAD_LAT`>1: go to HOLD and load `cnt = LOAD_LAT-2`.
  - HOLD, `cnt`>0: decrement `cnt`.
  - HOLD, `cnt`=0: go to IDLE.
  - `Stall` = (IDLE & `haz`) | HOLD.
- **Flush** has priority over everything:
  - next state is IDLE and `cnt` is cleared;
  - `Stall` is forced to 0 in the flush cycle.
- **Simultaneous events.**
  - `haz` in the cycle HOLD exits is ignored. The bubbled ID/EX slot can no longer hold the load.
  - Forwarding selects stay valid during `Stall`.

## Timing
- Forwarding selects and `haz` are zero-latency combinational from inputs.
- Total `Stall` cycles per hazard = `LOAD_LAT`, contiguous, starting in the detection cycle.
- **Reset** (`Rst_n`=0 at a rising edge):
  - state IDLE, `cnt` = 0, stats counters = 0.
  - While `Rst_n` is low, all selects are 0, `Stall` is 0, `PC_Write` and `IF_ID_Write` are 1, and `ID_EX_Bubble` is 0.
- Reset asserted mid-HOLD aborts the sequence; the first post-reset cycle is IDLE.

## Configuration
- **`HAZARD_STATS_EN` defined:** adds two outputs.
  - `Stall_Count` out 16: counts cycles with `Stall`=1.
  - `Fwd_Count` out 16: counts cycles where either ALU select is non-zero.
  - Both saturate at 16'hFFFF and clear on reset.
- **`HAZARD_STATS_EN` undefined:** both ports and their counters are absent.

## Test plan
- **Dual-source priority.** `NUM_FWD`=2; `ID_EX_rs`=`ID_EX_rt`=5; both sources write r5 -> `ALU_input_rs`=`ALU_input_rt`=`WriteMEMData_Signal`=1.
- **r0 and per-operand independence.** `ID_EX_rs`=0, `ID_EX_rt`=7; source 0 writes r0; source 1 writes r7 -> rs=0, rt=2.
- **Single-cycle load-use.** `LOAD_LAT`=1; lw r8 in EX; decode reads r8 as rs -> `Stall`=1 for exactly 1 cycle; `PC_Write`=0 in that cycle only.
- **Multi-cycle load-use.** `LOAD_LAT`=3, same stimulus -> `Stall` high for 3 consecutive cycles, then 0. Repeat with `IF_ID_UsesRt`=0 and the rt match only -> no stall.
- **Flush and reset mid-HOLD.** `LOAD_LAT`=4; assert `Flush` in the 2nd stall cycle -> `Stall`=0 that cycle and after. Repeat using `Rst_n`=0 instead -> IDLE, all selects 0.
- **Stats (`HAZARD_STATS_EN` defined).** Three `LOAD_LAT`=2 hazards -> `Stall_Count`=6. Preload past 65535 cycles -> `Stall_Count` holds at 16'hFFFF.
